// File: rtl/exec_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : exec_pipe
//  Description : Handshaked execute stage. It contains the ALU, branch/jump
//                resolution, a byte-lane data memory with a synchronous
//                read, and an iterative shift-add multiplier. Results are
//                held in output registers until writeback consumes them.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                in_valid/ready - input handshake for ins, pc, reg1, reg2
//                out_valid/ready- output handshake for wra, result, nextpc
//                busy           - a load or a multiply is in progress
//  Revision    : 1.0 - initial release
// ============================================================================
module exec_pipe #(
    parameter int XLEN       = 32,
    parameter int DMEM_WORDS = 256,
    parameter bit MUL_EN     = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     ins,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] reg1,
    input  logic [XLEN-1:0] reg2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      wra,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] nextpc,
    output logic            busy
);

    localparam int AW = $clog2(DMEM_WORDS);
    localparam int NB = XLEN / 8;
    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] c_LD_W = 2'd0;
    localparam logic [1:0] c_LD_H = 2'd1;
    localparam logic [1:0] c_LD_B = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [4:0]        wra_q, wra_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   nextpc_q, nextpc_d;
    // Context of a multi-cycle op, captured at accept
    logic [4:0]        ldst_q, ldst_d;
    logic [XLEN-1:0]   npc_q, npc_d;
    logic [1:0]        lane_q, lane_d;
    logic [1:0]        ltype_q, ltype_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   rdata_q;
    logic [XLEN-1:0]   mem_q [DMEM_WORDS];

    // ------------------------------------------------------------------
    // Handshake and operand helpers
    // ------------------------------------------------------------------
    logic            w_out_free;
    logic            w_accept;
    logic [5:0]      w_op;
    logic [4:0]      w_funct;
    logic [4:0]      w_shamt;
    logic [4:0]      w_rt;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_simm;
    logic [XLEN-1:0] w_zimm;
    logic [XLEN-1:0] w_pc1;
    logic [XLEN-1:0] w_btgt;
    logic [XLEN-1:0] w_jtgt;
    logic [XLEN-1:0] w_addr;
    logic [AW-1:0]   w_widx;
    logic            w_lt;
    logic            w_eq;

    assign w_out_free = ~out_valid_q | out_ready;
    assign in_ready   = (state_q == S_IDLE) & w_out_free;
    assign w_accept   = in_valid & in_ready;

    assign w_op    = ins[31:26];
    assign w_rt    = ins[20:16];
    assign w_rd    = ins[15:11];
    assign w_shamt = ins[10:6];
    assign w_funct = ins[4:0];
    assign w_simm  = {{(XLEN-16){ins[15]}}, ins[15:0]};
    assign w_zimm  = {{(XLEN-16){1'b0}}, ins[15:0]};
    assign w_pc1   = pc + XLEN'(1);
    assign w_btgt  = w_pc1 + w_simm;
    assign w_jtgt  = {{(XLEN-26){1'b0}}, ins[25:0]};
    assign w_addr  = reg1 + w_simm;
    assign w_widx  = w_addr[AW+1:2];
    assign w_lt    = $signed(reg1) < $signed(reg2);
    assign w_eq    = (reg1 == reg2);

    // rs field and bit 5 are decoded upstream; the high address bits
    // beyond the memory depth are ignored (address wraps).
    logic w_unused;
    assign w_unused = ^{ins[25:21], ins[5], w_addr[XLEN-1:AW+2]};

    // ------------------------------------------------------------------
    // Decode / single-cycle results
    // ------------------------------------------------------------------
    logic [4:0]      w_wra;
    logic [XLEN-1:0] w_res;
    logic [XLEN-1:0] w_npc;
    logic            w_is_load;
    logic            w_is_mul;
    logic            w_is_store;
    logic [1:0]      w_ltype;
    logic [NB-1:0]   w_be;
    logic [XLEN-1:0] w_wd;

    always_comb begin
        w_wra      = 5'd0;
        w_res      = '1;
        w_npc      = w_pc1;
        w_is_load  = 1'b0;
        w_is_mul   = 1'b0;
        w_is_store = 1'b0;
        w_ltype    = c_LD_W;
        w_be       = '0;
        w_wd       = reg2;
        case (w_op)
            6'd0: begin
                w_wra = w_rd;
                case (w_funct)
                    5'd0:  w_res = reg1 + reg2;
                    5'd1:  w_res = reg1 - reg2;
                    5'd2: begin
                        if (MUL_EN) begin
                            w_is_mul = 1'b1;
                        end else begin
                            w_wra = 5'd0;
                        end
                    end
                    5'd8:  w_res = reg1 & reg2;
                    5'd9:  w_res = reg1 | reg2;
                    5'd10: w_res = reg1 ^ reg2;
                    5'd11: w_res = ~(reg1 & reg2);
                    5'd16: w_res = reg1 << w_shamt;
                    5'd17: w_res = reg1 >> w_shamt;
                    5'd18: w_res = $signed(reg1) >>> w_shamt;
                    default: w_res = '1;
                endcase
            end
            6'd1: begin w_wra = w_rt; w_res = reg1 + w_simm;  end
            6'd3: begin w_wra = w_rt; w_res = w_zimm << 16;   end
            6'd4: begin w_wra = w_rt; w_res = reg1 & w_zimm;  end
            6'd5: begin w_wra = w_rt; w_res = reg1 | w_zimm;  end
            6'd6: begin w_wra = w_rt; w_res = reg1 ^ w_zimm;  end
            6'd16: begin w_wra = w_rt; w_is_load = 1'b1; w_ltype = c_LD_W; end
            6'd18: begin w_wra = w_rt; w_is_load = 1'b1; w_ltype = c_LD_H; end
            6'd20: begin w_wra = w_rt; w_is_load = 1'b1; w_ltype = c_LD_B; end
            6'd24: begin
                w_res      = '0;
                w_is_store = 1'b1;
                w_be       = '1;
            end
            6'd26: begin
                // Half store: misaligned addresses land on the aligned pair
                w_res      = '0;
                w_is_store = 1'b1;
                w_wd       = {(NB/2){reg2[15:0]}};
                w_be[{w_addr[1], 1'b0}] = 1'b1;
                w_be[{w_addr[1], 1'b1}] = 1'b1;
            end
            6'd28: begin
                w_res      = '0;
                w_is_store = 1'b1;
                w_wd       = {NB{reg2[7:0]}};
                w_be[w_addr[1:0]] = 1'b1;
            end
            6'd32: begin w_res = '0; w_npc = w_eq          ? w_btgt : w_pc1; end
            6'd33: begin w_res = '0; w_npc = !w_eq         ? w_btgt : w_pc1; end
            6'd34: begin w_res = '0; w_npc = w_lt          ? w_btgt : w_pc1; end
            6'd35: begin w_res = '0; w_npc = (w_lt | w_eq) ? w_btgt : w_pc1; end
            6'd40: begin w_res = '0; w_npc = w_jtgt; end
            6'd41: begin w_wra = 5'd31; w_res = w_pc1; w_npc = w_jtgt; end
            6'd42: begin w_res = '0; w_npc = reg1; end
            default: begin
                w_wra = 5'd0;
                w_res = '1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load data formatting (from the word read at accept)
    // ------------------------------------------------------------------
    logic [15:0]     w_half;
    logic [7:0]      w_byte;
    logic [XLEN-1:0] w_ld_res;

    always_comb begin
        w_half = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        w_byte = rdata_q[{lane_q, 3'b000} +: 8];
        case (ltype_q)
            c_LD_H:  w_ld_res = {{(XLEN-16){w_half[15]}}, w_half};
            c_LD_B:  w_ld_res = {{(XLEN-8){w_byte[7]}}, w_byte};
            default: w_ld_res = rdata_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_acc_nx;
    logic            w_mul_last;

    assign w_acc_nx   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign w_mul_last = (cnt_q == CW'(XLEN - 1));

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        wra_d       = wra_q;
        result_d    = result_q;
        nextpc_d    = nextpc_q;
        ldst_d      = ldst_q;
        npc_d       = npc_q;
        lane_d      = lane_q;
        ltype_d     = ltype_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_load) begin
                        state_d = S_LOAD;
                        ldst_d  = w_wra;
                        npc_d   = w_pc1;
                        lane_d  = w_addr[1:0];
                        ltype_d = w_ltype;
                    end else if (w_is_mul) begin
                        state_d  = S_MUL;
                        ldst_d   = w_wra;
                        npc_d    = w_pc1;
                        mcand_d  = reg1;
                        mplier_d = reg2;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        out_valid_d = 1'b1;
                        wra_d       = w_wra;
                        result_d    = w_res;
                        nextpc_d    = w_npc;
                    end
                end
            end
            S_LOAD: begin
                if (w_out_free) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    wra_d       = ldst_q;
                    result_d    = w_ld_res;
                    nextpc_d    = npc_q;
                end
            end
            S_MUL: begin
                // The final step is held back only if the output is still occupied
                if (!w_mul_last || w_out_free) begin
                    acc_d    = w_acc_nx;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                    if (w_mul_last) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b1;
                        wra_d       = ldst_q;
                        result_d    = w_acc_nx;
                        nextpc_d    = npc_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            wra_q       <= 5'd0;
            result_q    <= '0;
            nextpc_q    <= '0;
            ldst_q      <= 5'd0;
            npc_q       <= '0;
            lane_q      <= 2'd0;
            ltype_q     <= c_LD_W;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            wra_q       <= wra_d;
            result_q    <= result_d;
            nextpc_q    <= nextpc_d;
            ldst_q      <= ldst_d;
            npc_q       <= npc_d;
            lane_q      <= lane_d;
            ltype_q     <= ltype_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Data memory: not reset. Read happens at the load's accept edge, so a
    // store accepted earlier is already visible.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept && w_is_load) begin
            rdata_q <= mem_q[w_widx];
        end
        if (!rst && w_accept && w_is_store) begin
            for (int b = 0; b < NB; b++) begin
                if (w_be[b]) begin
                    mem_q[w_widx][8*b +: 8] <= w_wd[8*b +: 8];
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign wra       = wra_q;
    assign result    = result_q;
    assign nextpc    = nextpc_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
